// File: rtl/matrix_loader.sv
// 64-byte signed matrix buffer: sequential row-major load, two read ports.
// Optional running checksum enabled by defining LOADER_CHECKSUM_EN.
module matrix_loader #(
  parameter int ROW_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_valid,
  input  logic signed [7:0] wr_data,
  output logic              wr_ready,
  input  logic        [5:0] rd_addr_1,
  input  logic        [5:0] rd_addr_2,
  output logic signed [7:0] rd_data_1,
  output logic signed [7:0] rd_data_2,
  output logic              row_done,
  output logic              done,
  output logic        [7:0] checksum
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL
  } state_t;

  localparam logic [5:0] ROW_MSK = 6'(ROW_LEN - 1);

  state_t            state;
  state_t            state_nxt;
  logic        [5:0] wr_ptr;
  logic              xfer;
  logic              last;
  logic signed [7:0] mem [64];

  assign wr_ready = (state == LOAD);
  assign done     = (state == FULL);
  assign xfer     = wr_valid && wr_ready && !start;
  assign last     = (wr_ptr == 6'd63);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a new start always wins over a transfer
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      start:        state_nxt = LOAD;
      xfer && last: state_nxt = FULL;
      default:      ;
    endcase
  end

  // Write pointer and end-of-row pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      row_done <= 1'b0;
    end else begin
      row_done <= xfer && ((wr_ptr & ROW_MSK) == ROW_MSK);
      if (start)     wr_ptr <= '0;
      else if (xfer) wr_ptr <= wr_ptr + 6'd1;
    end
  end

  // Storage, never reset so a load survives an abandoned reload
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr] <= wr_data;
  end

  // Registered reads, old data on a same-address write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_1 <= '0;
      rd_data_2 <= '0;
    end else begin
      rd_data_1 <= mem[rd_addr_1];
      rd_data_2 <= mem[rd_addr_2];
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Mod-256 sum of bytes accepted since the last start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     checksum <= '0;
    else if (start) checksum <= '0;
    else if (xfer)  checksum <= checksum + wr_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader.
// Checksum expectations follow LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_matrix_loader;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              wr_valid;
  logic signed [7:0] wr_data;
  logic              wr_ready;
  logic        [5:0] rd_addr_1;
  logic        [5:0] rd_addr_2;
  logic signed [7:0] rd_data_1;
  logic signed [7:0] rd_data_2;
  logic              row_done;
  logic              done;
  logic        [7:0] checksum;

  int n_chk  = 0;
  int n_fail = 0;
  int rd_cnt;

  matrix_loader #(.ROW_LEN(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_addr_1(rd_addr_1),
    .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1),
    .rd_data_2(rd_data_2),
    .row_done (row_done),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] csx(input logic [7:0] v);
`ifdef LOADER_CHECKSUM_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_addr_1 = '0;
    rd_addr_2 = '0;
    #3;
    chk("rst_wr_ready", 8'(wr_ready), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_row_done", 8'(row_done), 8'h0);
    chk("rst_rd1", rd_data_1, 8'h0);
    chk("rst_rd2", rd_data_2, 8'h0);
    chk("rst_cs", checksum, 8'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_wr_ready", 8'(wr_ready), 8'h0);

    // continuous load of 0..63
    do_start();
    chk("load_wr_ready", 8'(wr_ready), 8'h1);
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      tick();
      chk($sformatf("t1_row_done_%0d", i), 8'(row_done),
          8'((i % 8) == 7));
      if (i == 62) chk("t1_done_early", 8'(done), 8'h0);
    end
    wr_valid = 1'b0;
    chk("t1_done", 8'(done), 8'h1);
    chk("t1_full_ready", 8'(wr_ready), 8'h0);
    chk("t1_cs", checksum, csx(8'hE0));
    rd_addr_1 = 6'd5;
    rd_addr_2 = 6'd63;
    tick();
    chk("t1_rd5", rd_data_1, 8'd5);
    chk("t1_rd63", rd_data_2, 8'd63);
    chk("t1_row_done_off", 8'(row_done), 8'h0);

    // wr_valid toggling, 128 cycles
    do_start();
    chk("t2_done_clr", 8'(done), 8'h0);
    rd_cnt = 0;
    for (int k = 0; k < 128; k++) begin
      wr_valid = (k % 2) == 0;
      wr_data  = 8'(100 + k / 2);
      tick();
      if (row_done) rd_cnt++;
      chk($sformatf("t2_row_done_%0d", k), 8'(row_done),
          8'(((k % 2) == 0) && (((k / 2) % 8) == 7)));
    end
    wr_valid = 1'b0;
    chk("t2_rd_cnt", 8'(rd_cnt), 8'd8);
    chk("t2_done", 8'(done), 8'h1);
    rd_addr_1 = 6'd7;
    rd_addr_2 = 6'd40;
    tick();
    chk("t2_rd7", rd_data_1, 8'd107);
    chk("t2_rd40", rd_data_2, 8'h8C);

    // restart after 20 bytes, start colliding with a transfer
    do_start();
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h11;
      tick();
    end
    chk("t3_cs20", checksum, csx(8'h54));
    chk("t3_not_done", 8'(done), 8'h0);
    wr_data = 8'h55;
    do_start();
    chk("t3_cs_clr", checksum, 8'h00);
    chk("t3_ready", 8'(wr_ready), 8'h1);
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h7F;
      tick();
      if (i == 62) chk("t3_done_early", 8'(done), 8'h0);
    end
    wr_valid = 1'b0;
    chk("t3_done", 8'(done), 8'h1);
    chk("t3_cs", checksum, csx(8'hC0));
    for (int a = 0; a < 64; a++) begin
      rd_addr_1 = 6'(a);
      rd_addr_2 = 6'(63 - a);
      tick();
      chk($sformatf("t3_rd1_%0d", a), rd_data_1, 8'h7F);
      chk($sformatf("t3_rd2_%0d", a), rd_data_2, 8'h7F);
    end

    // writes ignored while FULL
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h80;
      rd_addr_1 = 6'(i);
      tick();
      chk($sformatf("t4_ready_%0d", i), 8'(wr_ready), 8'h0);
    end
    wr_valid = 1'b0;
    chk("t4_done", 8'(done), 8'h1);
    chk("t4_cs", checksum, csx(8'hC0));
    for (int a = 0; a < 64; a++) begin
      rd_addr_1 = 6'(a);
      rd_addr_2 = 6'(a);
      tick();
      chk($sformatf("t4_rd1_%0d", a), rd_data_1, 8'h7F);
      chk($sformatf("t4_rd2_%0d", a), rd_data_2, 8'h7F);
    end

    // 64 bytes of -1
    do_start();
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hFF;
      tick();
    end
    wr_valid = 1'b0;
    chk("t5_done", 8'(done), 8'h1);
    chk("t5_cs", checksum, csx(8'hC0));

    // async reset mid-load at byte 30
    do_start();
    rd_addr_1 = 6'd10;
    rd_addr_2 = 6'd0;
    for (int i = 0; i < 30; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(40 + i);
      tick();
    end
    wr_valid = 1'b0;
    chk("t6_pre_rd10", rd_data_1, 8'd50);
    chk("t6_pre_rd0", rd_data_2, 8'd40);
    chk("t6_pre_cs", checksum, csx(8'h63));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rd1", rd_data_1, 8'h0);
    chk("t6_rst_rd2", rd_data_2, 8'h0);
    chk("t6_rst_cs", checksum, 8'h0);
    chk("t6_rst_ready", 8'(wr_ready), 8'h0);
    chk("t6_rst_done", 8'(done), 8'h0);
    chk("t6_rst_row_done", 8'(row_done), 8'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h22;
      tick();
      chk($sformatf("t6_idle_ready_%0d", i), 8'(wr_ready), 8'h0);
    end
    wr_valid = 1'b0;
    tick();
    chk("t6_rd10", rd_data_1, 8'd50);
    chk("t6_rd0", rd_data_2, 8'd40);
    chk("t6_cs_idle", checksum, 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
